// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core load/store path and a bursting DMA port.
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W           = 32,
  parameter int CORE_MAX_WAIT    = 3,
  parameter int DMA_STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_last,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       perf_core_stall_cnt,
  output logic [31:0]       perf_dma_beat_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  localparam logic [3:0] CMW     = 4'(CORE_MAX_WAIT);
  localparam logic [3:0] DSL     = 4'(DMA_STARVE_LIMIT);

  logic [0:0] r_state;
  logic [3:0] r_core_wait;
  logic [3:0] r_dma_wait;
  logic       r_core_rd;
  logic       r_dma_rd;

  logic w_idle;
  logic w_core_sat;
  logic w_dma_sat;
  logic w_core_gnt;
  logic w_dma_gnt;

  // While reset is held the grant uses IDLE priority regardless of the stored state.
  always_comb begin
    w_idle     = (r_state == S_IDLE) | reset;
    w_core_sat = (r_core_wait >= CMW);
    w_dma_sat  = (r_dma_wait >= DSL);
    w_core_gnt = 1'b0;
    w_dma_gnt  = 1'b0;
    if (w_idle) begin
      w_dma_gnt  = dma_req & (~core_req | w_dma_sat);
      w_core_gnt = core_req & ~w_dma_gnt;
    end else begin
      w_core_gnt = core_req & (w_core_sat | ~dma_req);
      w_dma_gnt  = dma_req & ~w_core_gnt;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (w_dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign core_gnt    = w_core_gnt;
  assign dma_gnt     = w_dma_gnt;
  assign core_stall  = core_req & ~w_core_gnt;
  assign mem_en      = w_core_gnt | w_dma_gnt;
  assign core_rvalid = r_core_rd & ~reset;
  assign dma_rvalid  = r_dma_rd & ~reset;
  assign core_rdata  = core_rvalid ? mem_rdata : 32'd0;
  assign dma_rdata   = dma_rvalid ? mem_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_core_wait <= 4'd0;
      r_dma_wait  <= 4'd0;
      r_core_rd   <= 1'b0;
      r_dma_rd    <= 1'b0;
    end else begin
      if (core_req & ~w_core_gnt)
        r_core_wait <= w_core_sat ? r_core_wait : r_core_wait + 4'd1;
      else
        r_core_wait <= 4'd0;
      if (dma_req & ~w_dma_gnt)
        r_dma_wait <= w_dma_sat ? r_dma_wait : r_dma_wait + 4'd1;
      else
        r_dma_wait <= 4'd0;
      // A pre-empting core grant inside a burst keeps the burst open.
      case (r_state)
        S_IDLE:  if (w_dma_gnt & ~dma_last) r_state <= S_BURST;
        S_BURST: if (w_dma_gnt & dma_last)  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      r_core_rd <= w_core_gnt & ~core_we;
      r_dma_rd  <= w_dma_gnt & ~dma_we;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= 32'd0;
      r_perf_beat  <= 32'd0;
    end else begin
      if (core_stall)          r_perf_stall <= r_perf_stall + 32'd1;
      if (dma_req & w_dma_gnt) r_perf_beat  <= r_perf_beat + 32'd1;
    end
  end

  assign perf_core_stall_cnt = r_perf_stall;
  assign perf_dma_beat_cnt   = r_perf_beat;
`else
  assign perf_core_stall_cnt = 32'd0;
  assign perf_dma_beat_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a rule-level reference model,
// plus directed burst pre-emption and reset-mid-burst sequences.
module tb_dmem_arbiter;
  localparam int CMW = 3;
  localparam int DSL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        dma_req, dma_we, dma_last;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] perf_core_stall_cnt, perf_dma_beat_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .CORE_MAX_WAIT(CMW), .DMA_STARVE_LIMIT(DSL)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_core_stall_cnt(perf_core_stall_cnt), .perf_dma_beat_cnt(perf_dma_beat_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: how long each side has waited, whether a burst is open,
  // which side has a read in flight, and how many stalls/beats have occurred.
  int  m_cwait, m_dwait;
  bit  m_burst;
  bit  m_crd, m_drd;
  int  m_stalls, m_beats;
  bit  last_cg, last_dg;
  bit  obs_stall, obs_en;

  task automatic model_reset_state();
    m_cwait = 0; m_dwait = 0; m_burst = 0; m_crd = 0; m_drd = 0;
    m_stalls = 0; m_beats = 0;
  endtask

  // One clock: inputs already driven; check at negedge, advance model at posedge.
  task automatic step();
    bit cg, dg, xwe;
    logic [31:0] xaddr, xdata;
    mem_rdata = $urandom;
    @(negedge clk);
    if (!m_burst || reset) begin
      dg = dma_req && (!core_req || m_dwait >= DSL);
      cg = core_req && !dg;
    end else begin
      cg = core_req && (m_cwait >= CMW || !dma_req);
      dg = dma_req && !cg;
    end
    xwe = 0; xaddr = 0; xdata = 0;
    if (cg) begin xwe = core_we; xaddr = core_addr; xdata = core_wdata; end
    else if (dg) begin xwe = dma_we; xaddr = dma_addr; xdata = dma_wdata; end
    chk("core_gnt", 32'(core_gnt), 32'(cg));
    chk("dma_gnt", 32'(dma_gnt), 32'(dg));
    chk("core_stall", 32'(core_stall), 32'(core_req && !cg));
    chk("mem_en", 32'(mem_en), 32'(cg || dg));
    chk("mem_we", 32'(mem_we), 32'(xwe));
    chk("mem_addr", mem_addr, xaddr);
    chk("mem_wdata", mem_wdata, xdata);
    if (!reset) begin
      chk("core_rvalid", 32'(core_rvalid), 32'(m_crd));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(m_drd));
      chk("core_rdata", core_rdata, m_crd ? mem_rdata : 32'd0);
      chk("dma_rdata", dma_rdata, m_drd ? mem_rdata : 32'd0);
    end
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall", perf_core_stall_cnt, 32'(m_stalls));
    chk("perf_beats", perf_dma_beat_cnt, 32'(m_beats));
`else
    chk("perf_stall", perf_core_stall_cnt, 32'd0);
    chk("perf_beats", perf_dma_beat_cnt, 32'd0);
`endif
    obs_stall = core_stall;
    obs_en    = mem_en;
    last_cg = cg; last_dg = dg;
    @(posedge clk);
    if (reset) begin
      model_reset_state();
    end else begin
      m_cwait = (core_req && !cg) ? ((m_cwait + 1 > CMW) ? CMW : m_cwait + 1) : 0;
      m_dwait = (dma_req && !dg) ? ((m_dwait + 1 > DSL) ? DSL : m_dwait + 1) : 0;
      if (!m_burst && dg && !dma_last) m_burst = 1;
      else if (m_burst && dg && dma_last) m_burst = 0;
      m_crd = cg && !core_we;
      m_drd = dg && !dma_we;
      if (core_req && !cg) m_stalls++;
      if (dg) m_beats++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dma_req = 0; dma_we = 0; dma_last = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1;
    repeat (cycles) step();
    reset = 0;
  endtask

  int dma_left, beats, n_stall, n_en;
  bit core_done;

  initial begin
    reset = 1; mem_rdata = 0;
    idle_inputs();
    model_reset_state();
    last_cg = 0; last_dg = 0;
    #1;
    do_reset(2);

    // Core only: load then store back-to-back.
    core_req = 1; core_we = 0; core_addr = 32'h100; step();
    chk("s1_load_gnt", 32'(last_cg), 32'd1);
    core_we = 1; core_addr = 32'h104; core_wdata = 32'hDEADBEEF; step();
    idle_inputs(); step();
    step();

    // Six-beat DMA burst, core requests from beat 2 and pre-empts once.
    do_reset(1);
    beats = 0; core_done = 0; n_stall = 0; n_en = 0;
    for (int c = 0; c < 20 && beats < 6; c++) begin
      dma_req = 1; dma_we = 1; dma_last = (beats == 5);
      dma_addr = 32'h2000 + 32'(beats * 4); dma_wdata = $urandom;
      core_req = (c >= 1) && !core_done; core_we = 0; core_addr = 32'h300;
      step();
      n_stall += int'(obs_stall); n_en += int'(obs_en);
      if (last_dg) beats++;
      if (last_cg) core_done = 1;
    end
    idle_inputs(); step();
    n_en += int'(obs_en);
    chk("s3_stall_cycles", 32'(n_stall), 32'd3);
    chk("s3_mem_en_cycles", 32'(n_en), 32'd7);
`ifdef DMEM_ARB_PERF_EN
    chk("s3_perf_stall", perf_core_stall_cnt, 32'd3);
    chk("s3_perf_beats", perf_dma_beat_cnt, 32'd6);
`else
    chk("s3_perf_stall", perf_core_stall_cnt, 32'd0);
    chk("s3_perf_beats", perf_dma_beat_cnt, 32'd0);
`endif

    // Granted read, then a burst reset at beat 3, then a single-beat write.
    core_req = 1; core_we = 0; core_addr = 32'h40; step();
    core_req = 0;
    for (int b = 0; b < 3; b++) begin
      dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 32'h3000 + 32'(b * 4);
      reset = (b == 2);
      step();
    end
    reset = 0; idle_inputs();
    dma_req = 1; dma_we = 1; dma_last = 1; dma_addr = 32'h5000; dma_wdata = 32'h1234;
    step();
    chk("s5_single_gnt", 32'(last_dg), 32'd1);
    idle_inputs(); step();

    // Randomized traffic with legal hold-until-granted requesters.
    dma_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!(core_req && !last_cg)) begin
        core_req = ($urandom_range(99) < 50);
        core_we = $urandom_range(1); core_addr = $urandom; core_wdata = $urandom;
      end
      if (!(dma_req && !last_dg)) begin
        if (dma_req && last_dg) dma_left--;
        if (dma_left == 0 && $urandom_range(99) < 30) dma_left = $urandom_range(6, 1);
        dma_req = (dma_left > 0) && ($urandom_range(3) != 0);
        dma_we = $urandom_range(1); dma_addr = $urandom; dma_wdata = $urandom;
        dma_last = (dma_left == 1);
      end
      reset = ($urandom_range(99) == 0);
      if (reset) begin
        step();
        reset = 0; dma_left = 0; dma_req = 0; core_req = 0;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
